// File: rtl/ram_cmd_arbiter.sv
// Two-requester round-robin arbiter that serialises single RAM transactions
// into {cmd, payload} command strobes and returns one response pulse per request.
module ram_cmd_arbiter #(
  parameter int RD_TIMEOUT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  req_valid,
  output logic [1:0]  req_ready,
  input  logic [1:0]  req_we,
  input  logic [15:0] req_addr,
  input  logic [15:0] req_wdata,
  output logic [1:0]  rsp_valid,
  output logic [7:0]  rsp_rdata,
  output logic        rsp_err,
  output logic [9:0]  ram_din,
  output logic        ram_rx_valid,
  input  logic [7:0]  ram_dout,
  input  logic        ram_tx_valid
);

  typedef enum logic [2:0] {IDLE, CMD_A, CMD_D, WAIT_RD, RESP} state_t;

  localparam logic [3:0] CNT_LAST = 4'(RD_TIMEOUT - 1);

  state_t      state_q, state_d;
  logic        grant_q, grant_d;
  logic        last_grant_q, last_grant_d;
  logic        we_q, we_d;
  logic [7:0]  addr_q, addr_d;
  logic [7:0]  wdata_q, wdata_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [1:0]  rsp_valid_q, rsp_valid_d;
  logic [7:0]  rsp_rdata_q, rsp_rdata_d;
  logic        rsp_err_q, rsp_err_d;
  logic [9:0]  ram_din_q, ram_din_d;
  logic        ram_rx_valid_q, ram_rx_valid_d;

  logic        grant_any;
  logic        grant_sel;
  logic        sel_we;
  logic [7:0]  sel_addr;

  // On a tie the requester that did not win last time is chosen.
  assign grant_any = |req_valid;
  assign grant_sel = (&req_valid) ? ~last_grant_q : req_valid[1];
  assign sel_we    = grant_sel ? req_we[1] : req_we[0];
  assign sel_addr  = grant_sel ? req_addr[15:8] : req_addr[7:0];

  assign req_ready = (state_q == IDLE && rst_n && grant_any) ?
                     (grant_sel ? 2'b10 : 2'b01) : 2'b00;

  always_comb begin
    state_d        = state_q;
    grant_d        = grant_q;
    last_grant_d   = last_grant_q;
    we_d           = we_q;
    addr_d         = addr_q;
    wdata_d        = wdata_q;
    cnt_d          = cnt_q;
    rsp_valid_d    = 2'b00;
    rsp_rdata_d    = rsp_rdata_q;
    rsp_err_d      = rsp_err_q;
    ram_din_d      = ram_din_q;
    ram_rx_valid_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (grant_any) begin
          grant_d        = grant_sel;
          we_d           = sel_we;
          addr_d         = sel_addr;
          wdata_d        = grant_sel ? req_wdata[15:8] : req_wdata[7:0];
          ram_rx_valid_d = 1'b1;
          ram_din_d      = {(sel_we ? 2'b00 : 2'b10), sel_addr};
          state_d        = CMD_A;
        end
      end
      CMD_A: begin
        ram_rx_valid_d = 1'b1;
        ram_din_d      = {(we_q ? 2'b01 : 2'b11), (we_q ? wdata_q : 8'h00)};
        state_d        = CMD_D;
      end
      CMD_D: begin
        if (we_q) begin
          rsp_valid_d = grant_q ? 2'b10 : 2'b01;
          rsp_rdata_d = 8'h00;
          rsp_err_d   = 1'b0;
          state_d     = RESP;
        end else begin
          cnt_d   = 4'd0;
          state_d = WAIT_RD;
        end
      end
      WAIT_RD: begin
        // The rd-addr strobe cleared any stale valid, so a high level here is fresh.
        if (ram_tx_valid) begin
          rsp_valid_d = grant_q ? 2'b10 : 2'b01;
          rsp_rdata_d = ram_dout;
          rsp_err_d   = 1'b0;
          state_d     = RESP;
        end else if (cnt_q == CNT_LAST) begin
          rsp_valid_d = grant_q ? 2'b10 : 2'b01;
          rsp_rdata_d = 8'h00;
          rsp_err_d   = 1'b1;
          state_d     = RESP;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      RESP: begin
        last_grant_d = grant_q;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      grant_q        <= 1'b0;
      last_grant_q   <= 1'b1;
      we_q           <= 1'b0;
      addr_q         <= 8'h00;
      wdata_q        <= 8'h00;
      cnt_q          <= 4'd0;
      rsp_valid_q    <= 2'b00;
      rsp_rdata_q    <= 8'h00;
      rsp_err_q      <= 1'b0;
      ram_din_q      <= 10'h000;
      ram_rx_valid_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      grant_q        <= grant_d;
      last_grant_q   <= last_grant_d;
      we_q           <= we_d;
      addr_q         <= addr_d;
      wdata_q        <= wdata_d;
      cnt_q          <= cnt_d;
      rsp_valid_q    <= rsp_valid_d;
      rsp_rdata_q    <= rsp_rdata_d;
      rsp_err_q      <= rsp_err_d;
      ram_din_q      <= ram_din_d;
      ram_rx_valid_q <= ram_rx_valid_d;
    end
  end

  assign rsp_valid    = rsp_valid_q;
  assign rsp_rdata    = rsp_rdata_q;
  assign rsp_err      = rsp_err_q;
  assign ram_din      = ram_din_q;
  assign ram_rx_valid = ram_rx_valid_q;

endmodule
